// File: rtl/char_print_ctrl.sv
// -----------------------------------------------------------------------------
// char_print_ctrl
//   Sequences the core's `charprint` characters into the video character-map
//   RAM. Characters wait in a small FIFO. A cursor FSM writes printable codes,
//   handles LF / CR / BS, and scrolls the screen by copying rows through a
//   shared, grant-arbitrated VRAM port. Scanout owns VRAM priority, so every
//   access is held stable until it is granted.
//
// Optional feature (macro CHARPRINT_FORMFEED_EN):
//   When defined, 0x0C clears the whole screen and homes the cursor.
//   When undefined, 0x0C is ignored like any other non-printable code.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous reset, active low
//   charprint   one-cycle strobe; char_in is sampled with it
//   char_in     character code
//   busy        FIFO non-empty or FSM not idle
//   overflow    sticky: a character arrived while the FIFO was full
//   cursor_col  current cursor column
//   cursor_row  current cursor row
//   vram_req    VRAM access request
//   vram_gnt    request granted this cycle (the access happens in that cycle)
//   vram_adr    cell address = row*COLS + col
//   vram_we     write enable (read when 0)
//   vram_wd     write data
//   vram_rd     read data, valid the cycle after a granted read
// -----------------------------------------------------------------------------
module char_print_ctrl #(
  parameter int COLS  = 80,
  parameter int ROWS  = 30,
  parameter int AW    = 12,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    charprint,
  input  logic [7:0]              char_in,
  output logic                    busy,
  output logic                    overflow,
  output logic [$clog2(COLS)-1:0] cursor_col,
  output logic [$clog2(ROWS)-1:0] cursor_row,
  output logic                    vram_req,
  input  logic                    vram_gnt,
  output logic [AW-1:0]           vram_adr,
  output logic                    vram_we,
  output logic [7:0]              vram_wd,
  input  logic [7:0]              vram_rd
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int PW = $clog2(DEPTH);

  localparam logic [CW-1:0] COL_LAST      = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST      = RW'(ROWS - 1);
  localparam logic [AW-1:0] COLS_A        = AW'(COLS);
  localparam logic [AW-1:0] COPY_LAST     = AW'((ROWS - 1) * COLS - 1);
  localparam logic [AW-1:0] LAST_ROW_BASE = AW'((ROWS - 1) * COLS);
  localparam logic [AW-1:0] SCREEN_LAST   = AW'(ROWS * COLS - 1);
  localparam logic [PW:0]   FIFO_FULL_CNT = (PW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DISPATCH,
    S_WRITE,
    S_SCR_RD,
    S_SCR_WAIT,
    S_SCR_WR,
    S_CLR_ROW
`ifdef CHARPRINT_FORMFEED_EN
    , S_CLR_ALL
`endif
  } state_t;

  // ---------------------------------------------------------------------------
  // Pending-character FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    fifo_mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          fifo_full, fifo_empty, push, pop;

  state_t        state_q, state_d;
  logic [7:0]    char_q, char_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [AW-1:0] scr_q, scr_d;     // scroll / clear cell index
  logic [7:0]    data_q, data_d;   // cell captured during a scroll copy
  logic [AW-1:0] cell_adr;
  logic          access;

  assign fifo_full  = (count_q == FIFO_FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign push       = charprint && !fifo_full;
  assign pop        = (state_q == S_IDLE) && !fifo_empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    count_d    = count_q + (PW + 1)'(push) - (PW + 1)'(pop);
    overflow_d = overflow_q | (charprint & fifo_full);
  end

  // NOTE: storage arrays carry no reset; the pointers and count define which
  // entries are valid, so resetting the data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= char_in;
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      char_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      scr_q      <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      char_q     <= char_d;
      col_q      <= col_d;
      row_q      <= row_d;
      scr_q      <= scr_d;
      data_q     <= data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. The FSM only leaves an access state on a granted cycle.
  // ---------------------------------------------------------------------------
  assign access = vram_req && vram_gnt;

  // NOTE: every combinational output gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    char_d  = char_q;
    col_d   = col_q;
    row_d   = row_q;
    scr_d   = scr_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          char_d  = fifo_mem_q[rd_ptr_q];
          state_d = S_DISPATCH;
        end
      end
      S_DISPATCH: begin
        if (char_q >= 8'h20 && char_q <= 8'h7E) begin
          state_d = S_WRITE;
        end else begin
          state_d = S_IDLE;
          case (char_q)
            8'h0A: begin  // LF: carriage return plus row advance
              col_d = '0;
              if (row_q != ROW_LAST) begin
                row_d = row_q + RW'(1);
              end else begin
                scr_d   = '0;
                state_d = S_SCR_RD;
              end
            end
            8'h0D: col_d = '0;
            8'h08: begin  // BS: step back and blank the cell, no advance
              if (col_q != '0) begin
                col_d   = col_q - CW'(1);
                state_d = S_WRITE;
              end
            end
`ifdef CHARPRINT_FORMFEED_EN
            8'h0C: begin
              scr_d   = '0;
              state_d = S_CLR_ALL;
            end
`endif
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_WRITE: begin
        if (access) begin
          state_d = S_IDLE;
          if (char_q != 8'h08) begin
            if (col_q != COL_LAST) begin
              col_d = col_q + CW'(1);
            end else begin
              col_d = '0;
              if (row_q != ROW_LAST) begin
                row_d = row_q + RW'(1);
              end else begin
                scr_d   = '0;
                state_d = S_SCR_RD;
              end
            end
          end
        end
      end
      S_SCR_RD: begin
        if (access) state_d = S_SCR_WAIT;
      end
      S_SCR_WAIT: begin
        data_d  = vram_rd;
        state_d = S_SCR_WR;
      end
      S_SCR_WR: begin
        if (access) begin
          if (scr_q == COPY_LAST) begin
            scr_d   = LAST_ROW_BASE;
            state_d = S_CLR_ROW;
          end else begin
            scr_d   = scr_q + AW'(1);
            state_d = S_SCR_RD;
          end
        end
      end
      S_CLR_ROW: begin
        if (access) begin
          if (scr_q == SCREEN_LAST) begin
            col_d   = '0;
            state_d = S_IDLE;
          end else begin
            scr_d = scr_q + AW'(1);
          end
        end
      end
`ifdef CHARPRINT_FORMFEED_EN
      S_CLR_ALL: begin
        if (access) begin
          if (scr_q == SCREEN_LAST) begin
            col_d   = '0;
            row_d   = '0;
            state_d = S_IDLE;
          end else begin
            scr_d = scr_q + AW'(1);
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs. VRAM signals depend on registered state only, so they stay
  // stable while a request waits for its grant.
  // ---------------------------------------------------------------------------
  assign cell_adr = AW'(row_q) * COLS_A + AW'(col_q);

  always_comb begin
    vram_req = 1'b0;
    vram_adr = '0;
    vram_we  = 1'b0;
    vram_wd  = '0;
    case (state_q)
      S_WRITE: begin
        vram_req = 1'b1;
        vram_adr = cell_adr;
        vram_we  = 1'b1;
        vram_wd  = (char_q == 8'h08) ? 8'h20 : char_q;
      end
      S_SCR_RD: begin
        vram_req = 1'b1;
        vram_adr = scr_q + COLS_A;
      end
      S_SCR_WR: begin
        vram_req = 1'b1;
        vram_adr = scr_q;
        vram_we  = 1'b1;
        vram_wd  = data_q;
      end
      S_CLR_ROW: begin
        vram_req = 1'b1;
        vram_adr = scr_q;
        vram_we  = 1'b1;
        vram_wd  = 8'h20;
      end
`ifdef CHARPRINT_FORMFEED_EN
      S_CLR_ALL: begin
        vram_req = 1'b1;
        vram_adr = scr_q;
        vram_we  = 1'b1;
        vram_wd  = 8'h20;
      end
`endif
      default: ;
    endcase
  end

  assign busy       = !fifo_empty || (state_q != S_IDLE);
  assign overflow   = overflow_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

endmodule

// File: tb/tb_char_print_ctrl.sv
// -----------------------------------------------------------------------------
// tb_char_print_ctrl
//   Two instances: the default 80x30 screen (write traffic checked against a
//   scoreboard of expected VRAM writes) and a 4x3 screen backed by a small
//   VRAM model to exercise scrolling end to end.
// -----------------------------------------------------------------------------
module tb_char_print_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Default-size instance
  logic        b_cp, b_busy, b_ovf, b_req, b_gnt, b_we;
  logic [7:0]  b_ch, b_wd, b_rd;
  logic [6:0]  b_col;
  logic [4:0]  b_row;
  logic [11:0] b_adr;

  // 4x3 instance
  logic        s_cp, s_busy, s_ovf, s_req, s_gnt, s_we;
  logic [7:0]  s_ch, s_wd, s_rd;
  logic [1:0]  s_col, s_row;
  logic [3:0]  s_adr;

  char_print_ctrl u_big (
    .clk(clk), .reset(reset), .charprint(b_cp), .char_in(b_ch),
    .busy(b_busy), .overflow(b_ovf), .cursor_col(b_col), .cursor_row(b_row),
    .vram_req(b_req), .vram_gnt(b_gnt), .vram_adr(b_adr), .vram_we(b_we),
    .vram_wd(b_wd), .vram_rd(b_rd)
  );

  char_print_ctrl #(.COLS(4), .ROWS(3), .AW(4), .DEPTH(4)) u_small (
    .clk(clk), .reset(reset), .charprint(s_cp), .char_in(s_ch),
    .busy(s_busy), .overflow(s_ovf), .cursor_col(s_col), .cursor_row(s_row),
    .vram_req(s_req), .vram_gnt(s_gnt), .vram_adr(s_adr), .vram_we(s_we),
    .vram_wd(s_wd), .vram_rd(s_rd)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard for the default instance: expected writes in order
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [11:0] adr;
    logic [7:0]  dat;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;
  int   b_acc = 0;

  function automatic void expect_wr(input int adr, input logic [7:0] d);
    exp_t e;
    e.adr = 12'(adr);
    e.dat = d;
    sb_q.push_back(e);
  endfunction

  // Access happens at the posedge following a negedge with req && gnt.
  always @(negedge clk) begin
    if (reset && b_req && b_gnt) begin
      b_acc++;
      check("b_access_is_write", b_we, 1);
      check("sb_pending", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        sb_e = sb_q.pop_front();
        check("sb_adr", b_adr, sb_e.adr);
        check("sb_wd", b_wd, sb_e.dat);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // VRAM model for the 4x3 instance. Read data appears just after the
  // granted read's edge and is garbage (0xEE) otherwise.
  // ---------------------------------------------------------------------------
  logic [7:0] s_mem [16];
  logic       s_preload = 1'b0;
  logic       s_rd_pend = 1'b0;
  logic [3:0] s_rd_adr  = '0;
  int         s_acc = 0;

  always @(negedge clk) begin
    s_rd_pend = 1'b0;
    if (s_preload) begin
      for (int i = 0; i < 16; i++) s_mem[i] = 8'(8'h30 + i);
    end else if (reset && s_req && s_gnt) begin
      s_acc++;
      if (s_we) s_mem[s_adr] = s_wd;
      else begin
        s_rd_pend = 1'b1;
        s_rd_adr  = s_adr;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    s_rd = s_rd_pend ? s_mem[s_rd_adr] : 8'hEE;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic wait_b_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (b_busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(tag, b_busy, 0);
  endtask

  task automatic wait_s_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (s_busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(tag, s_busy, 0);
  endtask

  task automatic strobe_b(input logic [7:0] c);
    @(posedge clk); #1;
    b_cp = 1'b1;
    b_ch = c;
    @(posedge clk); #1;
    b_cp = 1'b0;
  endtask

  task automatic print_b(input logic [7:0] c);
    strobe_b(c);
    wait_b_idle("b_idle");
  endtask

  task automatic print_s(input logic [7:0] c);
    @(posedge clk); #1;
    s_cp = 1'b1;
    s_ch = c;
    @(posedge clk); #1;
    s_cp = 1'b0;
    wait_s_idle("s_idle");
  endtask

  task automatic check_b_cur(input string tag, input int r, input int c);
    check({tag, "_row"}, b_row, r);
    check({tag, "_col"}, b_col, c);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    int acc0;
    int cyc;
    logic found;

    reset = 1'b0;
    b_cp = 1'b0; b_ch = '0; b_gnt = 1'b1; b_rd = 8'h00;
    s_cp = 1'b0; s_ch = '0; s_gnt = 1'b1; s_rd = 8'hEE;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", b_busy, 0);
    check("rst_ovf", b_ovf, 0);
    check_b_cur("rst", 0, 0);
    check("rst_req", b_req, 0);
    check("rst_we", b_we, 0);
    check("rst_wd", b_wd, 0);
    check("rst_adr", b_adr, 0);
    check("rst_s_busy", s_busy, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // 'A' at cycle N -> write at N+3, idle at N+4
    expect_wr(0, 8'h41);
    @(posedge clk); #1;
    b_cp = 1'b1; b_ch = 8'h41;              // cycle N
    @(posedge clk); #1;
    b_cp = 1'b0;                           // cycle N+1
    @(negedge clk); check("lat_n1_req", b_req, 0);
    @(negedge clk); check("lat_n2_req", b_req, 0);
    @(negedge clk);                        // cycle N+3
    check("lat_n3_req", b_req, 1);
    check("lat_n3_we", b_we, 1);
    check("lat_n3_adr", b_adr, 0);
    check("lat_n3_wd", b_wd, 8'h41);
    @(negedge clk);                        // cycle N+4
    check("lat_n4_busy", b_busy, 0);
    check_b_cur("after_A", 0, 1);

    // Two LFs, then fill row 2 up to column 79
    print_b(8'h0A);
    check_b_cur("lf1", 1, 0);
    print_b(8'h0A);
    check_b_cur("lf2", 2, 0);
    for (int i = 0; i < 79; i++) begin
      logic [7:0] c;
      c = 8'(8'h61 + (i % 26));
      expect_wr(160 + i, c);
      print_b(c);
    end
    check_b_cur("row2_full", 2, 79);

    // 'Z' at the last column wraps to the next row
    expect_wr(239, 8'h5A);
    print_b(8'h5A);
    check_b_cur("wrap", 3, 0);

    // Grant held low: request must stay stable, cursor frozen
    @(posedge clk); #1;
    b_gnt = 1'b0;
    expect_wr(240, 8'h51);
    strobe_b(8'h51);
    n = 0;
    while (!b_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("stall_req_seen", b_req, 1);
    acc0 = b_acc;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("stall_req", b_req, 1);
      check("stall_adr", b_adr, 240);
      check("stall_we", b_we, 1);
      check("stall_wd", b_wd, 8'h51);
      check_b_cur("stall", 3, 0);
    end
    check("stall_no_access", b_acc, acc0);
    @(posedge clk); #1;
    b_gnt = 1'b1;
    wait_b_idle("stall_idle");
    check("stall_one_access", b_acc, acc0 + 1);
    check_b_cur("after_stall", 3, 1);

    // Overflow: park the FSM in a stalled WRITE, then 5 strobes into DEPTH=4
    @(posedge clk); #1;
    b_gnt = 1'b0;
    strobe_b(8'h42);
    n = 0;
    while (!b_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("ovf_parked", b_req, 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      b_cp = 1'b1;
      b_ch = 8'(8'h63 + k);
      @(negedge clk);
      check("ovf_not_yet", b_ovf, 0);
    end
    @(posedge clk); #1;
    b_cp = 1'b0;
    @(negedge clk);
    check("ovf_set", b_ovf, 1);
    check("ovf_busy", b_busy, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    #2;
    check("ovf_rst_ovf", b_ovf, 0);
    check_b_cur("ovf_rst", 0, 0);
    check("ovf_rst_busy", b_busy, 0);
    check("ovf_rst_req", b_req, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    b_gnt = 1'b1;
    @(negedge clk);
    check("post_rst_busy", b_busy, 0);

    // Move to (5,10)
    for (int i = 0; i < 5; i++) print_b(8'h0A);
    for (int i = 0; i < 10; i++) begin
      expect_wr(400 + i, 8'h20);
      print_b(8'h20);
    end
    check_b_cur("at_5_10", 5, 10);

    // 'a', BS, CR
    expect_wr(410, 8'h61);
    print_b(8'h61);
    check_b_cur("after_a", 5, 11);
    expect_wr(410, 8'h20);
    print_b(8'h08);
    check_b_cur("after_bs", 5, 10);
    acc0 = b_acc;
    print_b(8'h0D);
    check_b_cur("after_cr", 5, 0);
    check("cr_no_access", b_acc, acc0);
    print_b(8'h08);
    check_b_cur("bs_col0", 5, 0);
    check("bs_col0_no_access", b_acc, acc0);

    // Non-printable codes at the range edges are ignored
    print_b(8'h01);
    print_b(8'h7F);
    print_b(8'h1F);
    check("ignored_no_access", b_acc, acc0);
    check_b_cur("ignored", 5, 0);

    // Printable range boundaries
    expect_wr(400, 8'h7E);
    print_b(8'h7E);
    expect_wr(401, 8'h20);
    print_b(8'h20);
    check_b_cur("printable_edges", 5, 2);

    // ---------------- 4x3 scroll ----------------
    print_s(8'h0A);
    print_s(8'h0A);
    print_s(8'h61);
    print_s(8'h62);
    print_s(8'h63);
    check("s_pre_row", s_row, 2);
    check("s_pre_col", s_col, 3);
    @(posedge clk); #1;
    s_preload = 1'b1;
    @(posedge clk); #1;
    s_preload = 1'b0;
    acc0 = s_acc;

    @(posedge clk); #1;
    s_cp = 1'b1; s_ch = 8'h58;
    @(posedge clk); #1;
    s_cp = 1'b0;
    found = 1'b0;
    n = 0;
    while (!found && n < 20) begin
      @(negedge clk);
      if (s_req && s_gnt && s_we && s_adr == 4'd11) found = 1'b1;
      n++;
    end
    check("s_x_write_seen", found, 1);
    check("s_x_wd", s_wd, 8'h58);
    cyc = 0;
    @(negedge clk);
    while (s_busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    check("s_scroll_cycles", cyc, 28);
    check("s_scroll_accesses", s_acc - acc0, 21);
    check("s_post_row", s_row, 2);
    check("s_post_col", s_col, 0);
    for (int i = 0; i < 12; i++) begin
      logic [7:0] e;
      if (i < 7)       e = 8'(8'h34 + i);
      else if (i == 7) e = 8'h58;
      else             e = 8'h20;
      check($sformatf("s_cell%0d", i), s_mem[i], e);
    end
    check("s_ovf", s_ovf, 0);

    check("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/char_print_ctrl.md
Name: char_print_ctrl

Overview:
- Sequences character output for the multicycle core's `charprint` instruction into the video character-map RAM.
- Buffers printed characters in a small FIFO and tracks the text cursor.
- Handles control characters (LF, CR, BS) and scrolls the screen by copying rows through a shared, grant-arbitrated VRAM port.
- Scanout owns VRAM priority; this block only accesses VRAM when granted.

Parameters:
- COLS, 80, characters per row
- ROWS, 30, rows per screen
- AW, 12, VRAM address width; must satisfy 2^AW >= COLS*ROWS
- DEPTH, 4, pending-character FIFO depth (power of two, >= 2)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- charprint  in  1  one-cycle strobe from core CHAREX state
- char_in  in  8  character code (core writedata[7:0]), sampled with charprint
- busy  out  1  FIFO non-empty or FSM not IDLE
- overflow  out  1  sticky: a charprint arrived while FIFO full
- cursor_col  out  $clog2(COLS)  current column
- cursor_row  out  $clog2(ROWS)  current row
- vram_req  out  1  access request
- vram_gnt  in  1  access granted this cycle
- vram_adr  out  AW  cell address = row*COLS + col
- vram_we  out  1  write enable (read when 0)
- vram_wd  out  8  write data
- vram_rd  in  8  read data, valid the cycle after a granted read

Behaviour:
- Reset (async, low) sets all outputs to 0: FIFO empty, FSM in IDLE, cursor at (0,0), overflow cleared.
- FIFO push:
  - charprint=1 and FIFO not full: push char_in.
  - FIFO full: drop char_in and set overflow.
  - Push and pop in the same cycle are both legal.
- VRAM handshake:
  - vram_req, vram_adr, vram_we and vram_wd stay stable until a cycle with vram_req && vram_gnt.
  - That cycle is the access; the FSM advances only on a granted cycle.
  - vram_we=0 and vram_wd=0 whenever vram_req=0.
- FSM states: IDLE, DISPATCH, WRITE, SCR_RD, SCR_WAIT, SCR_WR, CLR_ROW.
- IDLE: if FIFO not empty, pop into the char register and go to DISPATCH.
- DISPATCH decodes the char register:
  - 0x20-0x7E (printable): go to WRITE at (row,col).
  - 0x0A (LF): col=0, then row advance.
  - 0x0D (CR): col=0, then IDLE.
  - 0x08 (BS): if col>0, col-1 and WRITE 0x20 at the new position with no advance; else IDLE.
  - Any other code: ignored, go to IDLE.
- WRITE completes on grant. For a printable char:
  - col < COLS-1: col+1, then IDLE.
  - col = COLS-1: col=0, then row advance.
- Row advance:
  - row < ROWS-1: row+1, then IDLE.
  - row = ROWS-1: start scroll with scroll index s=0.
- Scroll, for s = 0 .. (ROWS-1)*COLS-1:
  - SCR_RD reads adr s+COLS (granted).
  - SCR_WAIT captures vram_rd.
  - SCR_WR writes the captured value to adr s (granted).
- CLR_ROW: after the copy, write 0x20 to every cell of row ROWS-1, ascending.
- End of scroll: row stays ROWS-1, col=0, go to IDLE.
- Latency, with gnt held high:
  - charprint in cycle N gives the printable VRAM write in cycle N+3 (push N, pop N+1, DISPATCH N+2, WRITE N+3).
  - Scroll takes (ROWS-1)*COLS*3 + COLS cycles.
- Arithmetic: address uses an AW-bit multiply-add; no wrap beyond COLS*ROWS-1 is ever generated.
- The FIFO keeps accepting during scroll; excess characters set overflow.
- Cursor outputs update the cycle after the state transition that changes them.
- Reset mid-scroll aborts the scroll immediately. Screen contents are then undefined; registers follow the reset values.

Optional Feature:
- Macro CHARPRINT_FORMFEED_EN.
- Defined: 0x0C in DISPATCH enters CLR_ALL, which writes 0x20 to adr 0..COLS*ROWS-1 (granted, ascending), then cursor=(0,0) and IDLE.
- Undefined: 0x0C is ignored like any other non-printable code, and CLR_ALL does not exist.

Test Plan:
- gnt=1, charprint 'A'(0x41) at cycle N -> vram_we=1, adr=0, wd=0x41 at N+3; cursor (0,1); busy low at N+4.
- Cursor at (2,79), print 'Z' -> write adr 239 (2*80+79) with 0x5A; cursor (3,0).
- gnt held 0 for 10 cycles during WRITE -> adr/we/wd stable, cursor unchanged; write occurs on the first gnt=1 cycle.
- COLS=4, ROWS=3, cells preloaded 0..11 with values 0x30+i, cursor (2,3), print 'X' -> final cells: 0-3=0x34-0x37, 4-6=0x38-0x3A, 7=0x58, 8-11=0x20; cursor (2,0).
- gnt=0, five charprint strobes with DEPTH=4 -> fifth dropped, overflow=1; assert reset=0 -> overflow=0, cursor (0,0), busy=0.
- Sequence 'a', 0x08, 0x0D at (5,10) -> adr 410=0x61, then adr 410=0x20 with cursor (5,10), then cursor (5,0); BS at col 0 gives no VRAM access.
